// File: rtl/bringup_vram_march_if.sv
// VRAM pin bundle shared by chips A and B: address, strobes, level-shifter directions and split data pins.
interface bringup_vram_march_if;
    logic        lvl_va_dir;
    logic        lvl_vd_dir;
    logic        vd_oe;
    logic        vrd_n;
    logic        vawr_n;
    logic        vbwr_n;
    logic        va14;
    logic [13:0] vaa;
    logic [13:0] vab;
    logic [7:0]  vda_o;
    logic [7:0]  vdb_o;
    logic [7:0]  vda_i;
    logic [7:0]  vdb_i;

    modport master (
        output lvl_va_dir, lvl_vd_dir, vd_oe, vrd_n, vawr_n, vbwr_n,
        output va14, vaa, vab, vda_o, vdb_o,
        input  vda_i, vdb_i
    );

    modport slave (
        input  lvl_va_dir, lvl_vd_dir, vd_oe, vrd_n, vawr_n, vbwr_n,
        input  va14, vaa, vab, vda_o, vdb_o,
        output vda_i, vdb_i
    );
endinterface

// File: rtl/bringup_vram_march.sv
// VRAM bringup tester: writes a mode-selected pattern (chip B gets the inverse) to every address,
// reads everything back and reports pass, error count and the first failing address/data.
module bringup_vram_march #(
    parameter int ADDR_BITS   = 15,
    parameter int STEP_CYCLES = 120,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           mode,
    bringup_vram_march_if.master vram,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [15:0]          err_count,
    output logic [14:0]          fail_addr,
    output logic [15:0]          fail_data,
    output logic                 led7,
    output logic                 led8
);

    localparam int                   CW        = $clog2(STEP_CYCLES);
    localparam logic [CW-1:0]        LAST_STEP = CW'(STEP_CYCLES - 1);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_SETUP,
        S_W_STROBE,
        S_W_HOLD,
        S_R_ADDR,
        S_R_STROBE,
        S_FINISH
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_step;
    logic [ADDR_BITS-1:0] r_addr;
    logic [1:0]           r_mode;
    logic                 r_vd_dir;
    logic                 r_vrd_n;
    logic                 r_vwr_n;
    logic [7:0]           r_vda;
    logic [7:0]           r_vdb;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;
    logic [15:0]          r_err_count;
    logic [14:0]          r_fail_addr;
    logic [15:0]          r_fail_data;

    logic                 w_last_step;
    logic                 w_last_addr;
    logic [ADDR_BITS-1:0] w_addr_next;
    logic [14:0]          w_addr15;
    logic [7:0]           w_exp_a;
    logic                 w_mismatch;

    function automatic logic [7:0] pattern(input logic [1:0] m, input logic [ADDR_BITS-1:0] a);
        logic [7:0] a8;
        a8 = 8'(a);
        case (m)
            2'd0:    return a8;
            2'd1:    return ~a8;
            2'd2:    return a8[0] ? 8'hAA : 8'h55;
            default: return 8'h00;
        endcase
    endfunction

    assign w_last_step = (r_step == LAST_STEP);
    assign w_last_addr = (r_addr == LAST_ADDR);
    assign w_addr_next = r_addr + 1'b1;
    assign w_addr15    = 15'(r_addr);
    assign w_exp_a     = pattern(r_mode, r_addr);
    // Chip B always holds the inverse of chip A, so a bridged data bus shows up as a mismatch.
    assign w_mismatch  = (vram.vda_i != w_exp_a) || (vram.vdb_i != ~w_exp_a);

    // NOTE: every register below uses non-blocking assignments so all of them update from the same pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_step      <= '0;
            r_addr      <= '0;
            r_mode      <= 2'd0;
            r_vd_dir    <= 1'b0;
            r_vrd_n     <= 1'b1;
            r_vwr_n     <= 1'b1;
            r_vda       <= 8'h00;
            r_vdb       <= 8'h00;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= 16'd0;
            r_fail_addr <= 15'd0;
            r_fail_data <= 16'd0;
        end else begin
            if (r_state inside {S_IDLE, S_FINISH} || w_last_step) begin
                r_step <= '0;
            end else begin
                r_step <= r_step + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_W_SETUP;
                        r_addr      <= '0;
                        r_mode      <= mode;
                        r_vd_dir    <= 1'b1;
                        r_vda       <= pattern(mode, '0);
                        r_vdb       <= ~pattern(mode, '0);
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_err_count <= 16'd0;
                        r_fail_addr <= 15'd0;
                        r_fail_data <= 16'd0;
                    end
                end

                S_W_SETUP: begin
                    if (w_last_step) begin
                        r_state <= S_W_STROBE;
                        r_vwr_n <= 1'b0;
                    end
                end

                S_W_STROBE: begin
                    if (w_last_step) begin
                        r_state <= S_W_HOLD;
                        r_vwr_n <= 1'b1;
                    end
                end

                S_W_HOLD: begin
                    if (w_last_step) begin
                        r_addr <= w_addr_next;
                        if (w_last_addr) begin
                            // Strobes are already high here, so turning the data bus around is safe.
                            r_state  <= S_R_ADDR;
                            r_vd_dir <= 1'b0;
                        end else begin
                            r_state <= S_W_SETUP;
                            r_vda   <= pattern(r_mode, w_addr_next);
                            r_vdb   <= ~pattern(r_mode, w_addr_next);
                        end
                    end
                end

                S_R_ADDR: begin
                    if (w_last_step) begin
                        r_state <= S_R_STROBE;
                        r_vrd_n <= 1'b0;
                    end
                end

                S_R_STROBE: begin
                    if (w_last_step) begin
                        r_vrd_n <= 1'b1;
                        if (w_mismatch) begin
                            if (r_err_count != 16'hFFFF) begin
                                r_err_count <= r_err_count + 16'd1;
                            end
                            if (r_err_count == 16'd0) begin
                                r_fail_addr <= w_addr15;
                                r_fail_data <= {vram.vda_i, vram.vdb_i};
                            end
                        end
                        if (w_last_addr || (STOP_ON_ERR && w_mismatch)) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_state <= S_R_ADDR;
                            r_addr  <= w_addr_next;
                        end
                    end
                end

                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                    r_pass  <= (r_err_count == 16'd0);
                    r_busy  <= 1'b0;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign vram.lvl_va_dir = 1'b1;
    assign vram.lvl_vd_dir = r_vd_dir;
    assign vram.vd_oe      = r_vd_dir;
    assign vram.vrd_n      = r_vrd_n;
    assign vram.vawr_n     = r_vwr_n;
    assign vram.vbwr_n     = r_vwr_n;
    assign vram.va14       = w_addr15[14];
    assign vram.vaa        = w_addr15[13:0];
    assign vram.vab        = w_addr15[13:0];
    assign vram.vda_o      = r_vda;
    assign vram.vdb_o      = r_vdb;

    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err_count;
    assign fail_addr = r_fail_addr;
    assign fail_data = r_fail_data;
    assign led7      = r_busy ? r_step[CW-1] : r_done;
    assign led8      = r_pass;

endmodule

// File: tb/tb_bringup_vram_march.sv
// Bench for bringup_vram_march: two testers (STOP_ON_ERR 0 and 1), each wired to a 2x16x8 SRAM model
// whose data pins can be given a stuck bit on chip A or a wired-AND short between chips.
module tb_bringup_vram_march;
    localparam int AB          = 4;
    localparam int SC          = 4;
    localparam int DEPTH       = 1 << AB;
    localparam int FULL_CYCLES = 5 * SC * DEPTH + 2;

    typedef struct {
        int          cycles;
        int          errs;
        int          faddr;
        logic [15:0] fdata;
        bit          pass;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start     [2];
    logic [1:0]  mode      [2];
    logic        busy      [2];
    logic        done      [2];
    logic        pass      [2];
    logic [15:0] err_count [2];
    logic [14:0] fail_addr [2];
    logic [15:0] fail_data [2];
    logic        led7      [2];
    logic        led8      [2];

    int fault    = 0;  // 0 healthy, 1 chip A bit 3 stuck at 1, 2 A/B data buses wired-AND
    int n_cmp    = 0;
    int n_mis    = 0;
    int led7_bad = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : u
        bringup_vram_march_if bus ();
        logic [7:0]    mem_a [DEPTH];
        logic [7:0]    mem_b [DEPTH];
        logic [7:0]    drv_a, drv_b, pin_a, pin_b;
        logic [AB-1:0] idx;
        logic          quiet;
        logic          prev_oe    = 1'b0;
        logic          prev_quiet = 1'b1;
        int            viol       = 0;

        bringup_vram_march #(
            .ADDR_BITS   (AB),
            .STEP_CYCLES (SC),
            .STOP_ON_ERR (g == 1)
        ) dut (
            .clock     (clock),
            .reset     (reset),
            .start     (start[g]),
            .mode      (mode[g]),
            .vram      (bus),
            .busy      (busy[g]),
            .done      (done[g]),
            .pass      (pass[g]),
            .err_count (err_count[g]),
            .fail_addr (fail_addr[g]),
            .fail_data (fail_data[g]),
            .led7      (led7[g]),
            .led8      (led8[g])
        );

        assign idx   = bus.vaa[AB-1:0];
        assign quiet = bus.vrd_n && bus.vawr_n && bus.vbwr_n;

        // Bidirectional pins: FPGA drives when vd_oe, chips drive while read strobe is low, else pulled up.
        always_comb begin
            drv_a = bus.vd_oe ? bus.vda_o : (!bus.vrd_n ? mem_a[idx] : 8'hFF);
            drv_b = bus.vd_oe ? bus.vdb_o : (!bus.vrd_n ? mem_b[idx] : 8'hFF);
            pin_a = drv_a;
            pin_b = drv_b;
            if (fault == 1) begin
                pin_a = drv_a | 8'h08;
            end else if (fault == 2) begin
                pin_a = drv_a & drv_b;
                pin_b = drv_a & drv_b;
            end
        end

        assign bus.vda_i = pin_a;
        assign bus.vdb_i = pin_b;

        always @(posedge clock) begin
            if (!bus.vawr_n) mem_a[idx] <= pin_a;
            if (!bus.vbwr_n) mem_b[idx] <= pin_b;
        end

        always @(negedge clock) begin
            if (!reset) begin
                assert (!(bus.vd_oe && !bus.vrd_n)) else viol <= viol + 1;
                if ((bus.vd_oe != prev_oe && !(prev_quiet && quiet)) ||
                    (!bus.vawr_n && !bus.vd_oe) || (bus.vawr_n != bus.vbwr_n) ||
                    (bus.lvl_vd_dir != bus.vd_oe) || (bus.lvl_va_dir != 1'b1) ||
                    (bus.vab != bus.vaa) || (bus.va14 != 1'b0) || (bus.vaa[13:AB] != '0) ||
                    (bus.vd_oe && bus.vdb_o != ~bus.vda_o)) begin
                    viol <= viol + 1;
                end
            end
            prev_oe    <= bus.vd_oe;
            prev_quiet <= quiet;
        end
    end

    function automatic logic [7:0] pat(input logic [1:0] m, input int a);
        logic [7:0] a8;
        a8 = 8'(a);
        case (m)
            2'd0:    return a8;
            2'd1:    return ~a8;
            2'd2:    return (a % 2 == 1) ? 8'hAA : 8'h55;
            default: return 8'h00;
        endcase
    endfunction

    function automatic void pins(input int f, input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] pa, output logic [7:0] pb);
        pa = a;
        pb = b;
        if (f == 1) begin
            pa = a | 8'h08;
        end else if (f == 2) begin
            pa = a & b;
            pb = a & b;
        end
    endfunction

    // Whole-test outcome: memory image after the write pass, then the per-address read verdicts.
    function automatic exp_t model_run(input int stop, input logic [1:0] m, input int f);
        exp_t       e;
        logic [7:0] sa [DEPTH];
        logic [7:0] sb [DEPTH];
        logic [7:0] p, ra, rb;
        e.cycles = FULL_CYCLES;
        e.errs   = 0;
        e.faddr  = 0;
        e.fdata  = 16'h0000;
        for (int i = 0; i < DEPTH; i++) begin
            p = pat(m, i);
            pins(f, p, ~p, sa[i], sb[i]);
        end
        for (int i = 0; i < DEPTH; i++) begin
            p = pat(m, i);
            pins(f, sa[i], sb[i], ra, rb);
            if (ra !== p || rb !== ~p) begin
                if (e.errs == 0) begin
                    e.faddr = i;
                    e.fdata = {ra, rb};
                end
                e.errs++;
                if (stop != 0) begin
                    e.cycles = 3 * SC * DEPTH + 2 * SC * (i + 1) + 2;
                    break;
                end
            end
        end
        e.pass = (e.errs == 0);
        return e;
    endfunction

    // Entered and left one step after a rising edge; cycles counts edges from the one sampling start
    // through the one that raises done.
    task automatic run_test(input int g, input logic [1:0] m, input bit poke, output int cycles);
        bit seen;
        seen     = 1'b0;
        mode[g]  = m;
        start[g] = 1'b1;
        cycles   = 0;
        while (!seen && cycles < 3 * FULL_CYCLES) begin
            @(posedge clock);
            #1;
            cycles++;
            start[g] = poke && (cycles % 37 == 0);
            if (cycles == 1) begin
                n_cmp++;
                if (busy[g] !== 1'b1) begin
                    n_mis++;
                    $display("FAIL busy_after_start: got %b expected 1", busy[g]);
                end
            end
            if (done[g] === 1'b1) seen = 1'b1;
            else if (led7[g] !== (((cycles - 1) % SC) >= SC / 2)) led7_bad++;
        end
        start[g] = 1'b0;
        n_cmp++;
        if (!seen) begin
            n_mis++;
            $display("FAIL run_timeout: done not seen after %0d cycles", cycles);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        for (int g = 0; g < 2; g++) begin
            n_cmp++;
            if ({busy[g], done[g], pass[g], led7[g], led8[g]} !== 5'b0 || err_count[g] !== 16'd0 ||
                fail_addr[g] !== 15'd0 || fail_data[g] !== 16'd0) begin
                n_mis++;
                $display("FAIL reset_status[%0d]: got busy=%b done=%b pass=%b err=%0d faddr=%0h fdata=%0h expected all 0",
                         g, busy[g], done[g], pass[g], err_count[g], fail_addr[g], fail_data[g]);
            end
        end
        n_cmp++;
        if ({u[0].bus.vrd_n, u[0].bus.vawr_n, u[0].bus.vbwr_n, u[0].bus.lvl_va_dir} !== 4'b1111 ||
            {u[0].bus.vd_oe, u[0].bus.lvl_vd_dir, u[0].bus.va14} !== 3'b000 || u[0].bus.vaa !== 14'd0 ||
            u[0].bus.vda_o !== 8'h00 || u[0].bus.vdb_o !== 8'h00) begin
            n_mis++;
            $display("FAIL reset_bus: got rd=%b wa=%b wb=%b vadir=%b oe=%b addr=%0h da=%0h db=%0h expected 1 1 1 1 0 0 00 00",
                     u[0].bus.vrd_n, u[0].bus.vawr_n, u[0].bus.vbwr_n, u[0].bus.lvl_va_dir,
                     u[0].bus.vd_oe, u[0].bus.vaa, u[0].bus.vda_o, u[0].bus.vdb_o);
        end
        reset = 1'b0;
    endtask

    task automatic test_good();
        int cyc;
        int bad_cells;
        fault = 0;
        run_test(0, 2'd0, 1'b0, cyc);
        n_cmp++;
        if (cyc !== 322) begin n_mis++; $display("FAIL good_cycles: got %0d expected 322", cyc); end
        n_cmp++;
        if (pass[0] !== 1'b1 || led8[0] !== 1'b1 || err_count[0] !== 16'd0) begin
            n_mis++;
            $display("FAIL good_status: got pass=%b led8=%b err=%0d expected 1 1 0", pass[0], led8[0], err_count[0]);
        end
        n_cmp++;
        if (busy[0] !== 1'b0 || led7[0] !== 1'b1) begin
            n_mis++;
            $display("FAIL good_idle: got busy=%b led7=%b expected 0 1", busy[0], led7[0]);
        end
        bad_cells = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (u[0].mem_a[i] !== 8'(i) || u[0].mem_b[i] !== ~8'(i)) bad_cells++;
        end
        n_cmp++;
        if (bad_cells != 0) begin n_mis++; $display("FAIL good_memory: got %0d bad cells expected 0", bad_cells); end
    endtask

    task automatic test_stuck_bit();
        int cyc;
        fault = 1;
        run_test(0, 2'd0, 1'b0, cyc);
        n_cmp++;
        if (err_count[0] !== 16'd8 || fail_addr[0] !== 15'd0 || fail_data[0] !== 16'h08FF ||
            pass[0] !== 1'b0 || led8[0] !== 1'b0) begin
            n_mis++;
            $display("FAIL stuck_bit: got err=%0d faddr=%0h fdata=%h pass=%b led8=%b expected 8 0 08ff 0 0",
                     err_count[0], fail_addr[0], fail_data[0], pass[0], led8[0]);
        end
    endtask

    task automatic test_stuck_stop();
        int cyc;
        fault = 1;
        run_test(1, 2'd0, 1'b0, cyc);
        n_cmp++;
        if (cyc !== 202) begin n_mis++; $display("FAIL stop_cycles: got %0d expected 202", cyc); end
        n_cmp++;
        if (err_count[1] !== 16'd1 || fail_addr[1] !== 15'd0 || fail_data[1] !== 16'h08FF || pass[1] !== 1'b0) begin
            n_mis++;
            $display("FAIL stop_status: got err=%0d faddr=%0h fdata=%h pass=%b expected 1 0 08ff 0",
                     err_count[1], fail_addr[1], fail_data[1], pass[1]);
        end
    endtask

    task automatic test_short();
        int cyc;
        fault = 2;
        run_test(0, 2'd3, 1'b0, cyc);
        n_cmp++;
        if (err_count[0] !== 16'd16 || fail_addr[0] !== 15'd0 || fail_data[0] !== 16'h0000 || pass[0] !== 1'b0) begin
            n_mis++;
            $display("FAIL short: got err=%0d faddr=%0h fdata=%h pass=%b expected 16 0 0000 0",
                     err_count[0], fail_addr[0], fail_data[0], pass[0]);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int n;
        fault    = 0;
        mode[0]  = 2'($urandom_range(0, 3));
        start[0] = 1'b1;
        @(posedge clock);
        #1;
        start[0] = 1'b0;
        n = 0;
        while (u[0].bus.vawr_n !== 1'b0 && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        n_cmp++;
        if (u[0].bus.vawr_n !== 1'b0) begin n_mis++; $display("FAIL reach_w_strobe: got vawr_n=%b expected 0", u[0].bus.vawr_n); end
        reset = 1'b1;
        @(posedge clock);
        #1;
        n_cmp++;
        if ({u[0].bus.vrd_n, u[0].bus.vawr_n, u[0].bus.vbwr_n} !== 3'b111 || u[0].bus.vd_oe !== 1'b0 ||
            busy[0] !== 1'b0 || done[0] !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_mid: got strobes=%b%b%b oe=%b busy=%b done=%b expected 111 0 0 0",
                     u[0].bus.vrd_n, u[0].bus.vawr_n, u[0].bus.vbwr_n, u[0].bus.vd_oe, busy[0], done[0]);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        run_test(0, 2'd0, 1'b0, cyc);
        n_cmp++;
        if (cyc !== 322 || pass[0] !== 1'b1) begin
            n_mis++;
            $display("FAIL after_reset_run: got cycles=%0d pass=%b expected 322 1", cyc, pass[0]);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [1:0] m;
        fault = 0;
        m = 2'($urandom_range(0, 3));
        run_test(0, m, 1'b1, cyc);
        n_cmp++;
        if (cyc !== FULL_CYCLES || pass[0] !== 1'b1) begin
            n_mis++;
            $display("FAIL start_while_busy: got cycles=%0d pass=%b expected %0d 1", cyc, pass[0], FULL_CYCLES);
        end
        run_test(1, m, 1'b1, cyc);
        n_cmp++;
        if (cyc !== FULL_CYCLES || pass[1] !== 1'b1 || err_count[1] !== 16'd0) begin
            n_mis++;
            $display("FAIL back_to_back_stop: got cycles=%0d pass=%b err=%0d expected %0d 1 0",
                     cyc, pass[1], err_count[1], FULL_CYCLES);
        end
    endtask

    task automatic test_random();
        int cyc;
        int g;
        logic [1:0] m;
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            g     = $urandom_range(0, 1);
            m     = 2'($urandom_range(0, 3));
            fault = $urandom_range(0, 2);
            e     = model_run(g, m, fault);
            run_test(g, m, 1'b0, cyc);
            n_cmp++;
            if (cyc !== e.cycles || err_count[g] !== 16'(e.errs) || fail_addr[g] !== 15'(e.faddr) ||
                fail_data[g] !== e.fdata || pass[g] !== e.pass) begin
                n_mis++;
                $display("FAIL random[%0d] g=%0d mode=%0d fault=%0d: got cyc=%0d err=%0d faddr=%0h fdata=%h pass=%b expected %0d %0d %0h %h %b",
                         k, g, m, fault, cyc, err_count[g], fail_addr[g], fail_data[g], pass[g],
                         e.cycles, e.errs, e.faddr, e.fdata, e.pass);
            end
        end
    endtask

    task automatic test_protocol();
        n_cmp++;
        if (u[0].viol !== 0 || u[1].viol !== 0) begin
            n_mis++;
            $display("FAIL bus_protocol: got %0d/%0d violations expected 0", u[0].viol, u[1].viol);
        end
        n_cmp++;
        if (led7_bad !== 0) begin n_mis++; $display("FAIL led7_heartbeat: got %0d wrong cycles expected 0", led7_bad); end
    endtask

    initial begin
        start[0] = 1'b0;
        start[1] = 1'b0;
        mode[0]  = 2'd0;
        mode[1]  = 2'd0;
        test_reset();
        test_good();
        test_stuck_bit();
        test_stuck_stop();
        test_short();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not reach its summary in time");
        $fatal(1, "watchdog expired");
    end

endmodule
